// File: rtl/mem_pkg.sv
// Shared memory-side constants, LSU state encoding and alignment helpers.
package mem_pkg;

  localparam logic [1:0] RAM_MODE_BYTE    = 2'd0;
  localparam logic [1:0] RAM_MODE_HALF    = 2'd1;
  localparam logic [1:0] RAM_MODE_WORD    = 2'd2;
  localparam logic [1:0] RAM_MODE_INVALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SPLIT  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] offset);
    logic ok;
    case (mode)
      RAM_MODE_BYTE: ok = 1'b1;
      RAM_MODE_HALF: ok = (offset != 2'd3);
      RAM_MODE_WORD: ok = (offset == 2'd0);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Lane index of the final byte access when an access is split into bytes.
  function automatic logic [1:0] split_last(input logic [1:0] mode);
    logic [1:0] last;
    case (mode)
      RAM_MODE_HALF: last = 2'd1;
      default:       last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/lsu_load_assembler.sv
// Merges returned load bytes into their lanes and applies sign/zero extension.
module lsu_load_assembler
  import mem_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic        is_signed,
  input  logic        split,
  input  logic [1:0]  lane,
  input  logic [31:0] lane_buf,
  input  logic [31:0] ram_r_data,
  output logic [31:0] merged,
  output logic [31:0] result
);

  // Split accesses return one byte in bits [7:0]; drop it into its lane.
  always_comb begin
    merged = ram_r_data;
    if (split) begin
      merged = lane_buf;
      merged[{lane, 3'b000} +: 8] = ram_r_data[7:0];
    end else begin
      merged = ram_r_data;
    end
  end

  // Extend the merged word to 32 bits according to access size.
  always_comb begin
    result = merged;
    case (mode)
      RAM_MODE_BYTE: result = {{24{merged[7] & is_signed}}, merged[7:0]};
      RAM_MODE_HALF: result = {{16{merged[15] & is_signed}}, merged[15:0]};
      default:       result = merged;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a negedge-clocked data RAM; one request in flight.
// Define LSU_MISALIGN_EN to split misaligned accesses into byte accesses instead of rejecting them.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_mode,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic [1:0]        ram_write_mode,
  output logic [1:0]        ram_read_mode,
  output logic              ram_read_signed,
  input  logic [DATA_W-1:0] ram_r_data
);

  lsu_state_t        state_r, state_s;
  logic [1:0]        idx_r, idx_s;
  logic [ADDR_W-1:0] addr_r, src_addr_s, ram_addr_s;
  logic [1:0]        mode_r, src_mode_s, ram_mode_s;
  logic              we_r, src_we_s, ram_we_s;
  logic              signed_r, src_signed_s, ram_signed_s;
  logic [DATA_W-1:0] wdata_r, src_wdata_s, ram_w_data_s;
  logic [31:0]       lane_buf_r, merged_s, result_s;

  // Next-state and split-index sequencing.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        idx_s = 2'd0;
        if (req_valid && req_ready) begin
          if (req_mode == RAM_MODE_INVALID) begin
            state_s = RESP;
          end else if (is_aligned(req_mode, req_addr[1:0])) begin
            state_s = ACCESS;
          end else begin
`ifdef LSU_MISALIGN_EN
            state_s = SPLIT;
`else
            state_s = RESP;
`endif
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: state_s = RESP;
      SPLIT: begin
        if (idx_r == split_last(mode_r)) begin
          state_s = RESP;
          idx_s   = 2'd0;
        end else begin
          state_s = SPLIT;
          idx_s   = idx_r + 2'd1;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request fields come straight from the port on the accepting edge, else from the capture.
  always_comb begin
    if (state_r == IDLE) begin
      src_addr_s   = req_addr;
      src_mode_s   = req_mode;
      src_we_s     = req_we;
      src_signed_s = req_signed;
      src_wdata_s  = req_wdata;
    end else begin
      src_addr_s   = addr_r;
      src_mode_s   = mode_r;
      src_we_s     = we_r;
      src_signed_s = signed_r;
      src_wdata_s  = wdata_r;
    end
  end

  // RAM command for the cycle about to start; idle cycles present an inert command.
  always_comb begin
    ram_we_s     = 1'b0;
    ram_addr_s   = '0;
    ram_mode_s   = RAM_MODE_BYTE;
    ram_signed_s = 1'b0;
    ram_w_data_s = '0;
    case (state_s)
      ACCESS: begin
        ram_we_s     = src_we_s;
        ram_addr_s   = src_addr_s;
        ram_mode_s   = src_mode_s;
        ram_signed_s = src_signed_s;
        ram_w_data_s = src_wdata_s;
      end
      SPLIT: begin
        ram_we_s          = src_we_s;
        ram_addr_s        = src_addr_s + ADDR_W'(idx_s);
        ram_w_data_s[7:0] = src_wdata_s[{idx_s, 3'b000} +: 8];
      end
      default: ram_we_s = 1'b0;
    endcase
  end

  lsu_load_assembler u_asm (
    .mode       (mode_r),
    .is_signed  (signed_r),
    .split      (state_r == SPLIT),
    .lane       (idx_r),
    .lane_buf   (lane_buf_r),
    .ram_r_data (ram_r_data),
    .merged     (merged_s),
    .result     (result_s)
  );

  // Control state, request capture and load byte buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= 2'd0;
      addr_r     <= '0;
      mode_r     <= RAM_MODE_BYTE;
      we_r       <= 1'b0;
      signed_r   <= 1'b0;
      wdata_r    <= '0;
      lane_buf_r <= 32'd0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (state_r == IDLE && state_s != IDLE) begin
        addr_r   <= req_addr;
        mode_r   <= req_mode;
        we_r     <= req_we;
        signed_r <= req_signed;
        wdata_r  <= req_wdata;
      end
      if (state_r == SPLIT) begin
        lane_buf_r <= merged_s;
      end else if (state_r == IDLE) begin
        lane_buf_r <= 32'd0;
      end
    end
  end

  // Registered handshake, response and RAM command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rdata      <= '0;
      ram_we          <= 1'b0;
      ram_r_addr      <= '0;
      ram_w_addr      <= '0;
      ram_w_data      <= '0;
      ram_write_mode  <= RAM_MODE_BYTE;
      ram_read_mode   <= RAM_MODE_BYTE;
      ram_read_signed <= 1'b0;
    end else begin
      req_ready  <= (state_s == IDLE);
      resp_valid <= (state_s == RESP);
      // Only rejected requests jump straight from IDLE to RESP.
      resp_err   <= (state_r == IDLE) && (state_s == RESP);
      if (state_s == RESP) begin
        resp_rdata <= ((state_r == IDLE) || we_r) ? '0 : result_s;
      end
      ram_we          <= ram_we_s;
      ram_r_addr      <= ram_addr_s;
      ram_w_addr      <= ram_addr_s;
      ram_w_data      <= ram_w_data_s;
      ram_write_mode  <= ram_mode_s;
      ram_read_mode   <= ram_mode_s;
      ram_read_signed <= ram_signed_s;
    end
  end

endmodule
